// File: rtl/cprv_imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cprv_imem_responder
//  Description : Instruction memory with a valid/ready fetch port, one-cycle
//                synchronous read into an in-order response buffer, and a
//                backdoor write port for program loading.
//  Revision    : 1.0 - initial release
// ============================================================================
module cprv_imem_responder #(
  parameter int DATA_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int RSP_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_req_i,
  output logic                   ready_req_o,
  input  logic [DATA_WIDTH-1:0]  addr_req_i,
  output logic                   valid_rsp_o,
  input  logic                   ready_rsp_i,
  output logic [DATA_WIDTH-1:0]  data_rsp_o,
  output logic                   err_rsp_o,
  input  logic                   we_i,
  input  logic [DATA_WIDTH-1:0]  waddr_i,
  input  logic [INSTR_WIDTH-1:0] wdata_i
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

  // Program storage; deliberately never reset so code survives a core reset.
  logic [INSTR_WIDTH-1:0] mem_q [MEM_WORDS];

  // Response buffer: the memory read lands directly in the slot at wr_ptr,
  // which is what gives the one-cycle read latency.
  logic [INSTR_WIDTH-1:0] buf_data_q [RSP_DEPTH];
  logic [RSP_DEPTH-1:0]   buf_err_q;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic          accept;
  logic          pop;
  logic          req_err;
  logic          wr_ok;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] wr_idx;

  assign req_idx = addr_req_i[AW+1:2];
  assign wr_idx  = waddr_i[AW+1:2];

  // Misaligned or beyond the last word: anything above the index field set.
  assign req_err = (addr_req_i[1:0] != 2'b00) || ((addr_req_i >> (AW + 2)) != '0);
  assign wr_ok   = we_i && (waddr_i[1:0] == 2'b00) && ((waddr_i >> (AW + 2)) == '0);

  assign valid_rsp_o = (count_q != '0);
  assign pop         = valid_rsp_o && ready_rsp_i;
  // A full buffer can still take a request when its head leaves this cycle.
  assign ready_req_o = rst_n && ((count_q < DEPTH_C) || pop);
  assign accept      = valid_req_i && ready_req_o;

  assign data_rsp_o = valid_rsp_o ? DATA_WIDTH'(buf_data_q[rd_ptr_q]) : '0;
  assign err_rsp_o  = valid_rsp_o && buf_err_q[rd_ptr_q];

  // Next-state for pointers and occupancy; pointers wrap naturally at 2**PW.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Buffer control state, cleared asynchronously to drop all pending responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Read into the buffer slot; mem_q is sampled before this edge's write,
  // so a same-cycle write to the same word returns the old contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_data_q[wr_ptr_q] <= req_err ? '0 : mem_q[req_idx];
      buf_err_q[wr_ptr_q]  <= req_err;
    end
  end

  // Backdoor program load; invalid addresses are dropped silently.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_idx] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cprv_imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cprv_imem_responder
//  Description : Directed self-checking bench for cprv_imem_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cprv_imem_responder;

  localparam int DATA_WIDTH  = 64;
  localparam int INSTR_WIDTH = 32;
  localparam int MEM_WORDS   = 1024;
  localparam int RSP_DEPTH   = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   valid_req_i;
  logic                   ready_req_o;
  logic [DATA_WIDTH-1:0]  addr_req_i;
  logic                   valid_rsp_o;
  logic                   ready_rsp_i;
  logic [DATA_WIDTH-1:0]  data_rsp_o;
  logic                   err_rsp_o;
  logic                   we_i;
  logic [DATA_WIDTH-1:0]  waddr_i;
  logic [INSTR_WIDTH-1:0] wdata_i;

  int vectors   = 0;
  int miscompares = 0;
  logic [31:0] words [12];

  cprv_imem_responder #(
    .DATA_WIDTH (DATA_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .RSP_DEPTH  (RSP_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_req_i(valid_req_i),
    .ready_req_o(ready_req_o),
    .addr_req_i (addr_req_i),
    .valid_rsp_o(valid_rsp_o),
    .ready_rsp_i(ready_rsp_i),
    .data_rsp_o (data_rsp_o),
    .err_rsp_o  (err_rsp_o),
    .we_i       (we_i),
    .waddr_i    (waddr_i),
    .wdata_i    (wdata_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic v, input logic [63:0] a, input logic rr);
    valid_req_i = v;
    addr_req_i  = a;
    ready_rsp_i = rr;
  endtask

  // Check the response port for a valid response carrying the given word.
  task automatic chk_rsp(input string tag, input logic [31:0] w);
    chk({tag, "_valid"}, 64'(valid_rsp_o), 64'd1);
    chk({tag, "_err"},   64'(err_rsp_o),   64'd0);
    chk({tag, "_data"},  data_rsp_o,       {32'd0, w});
  endtask

  initial begin
    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_0093;
    words[2] = 32'h0020_0113;
    words[3] = 32'h0030_0193;
    for (int i = 4; i < 12; i++) words[i] = 32'hA000_0000 + 32'(i);

    rst_n = 1'b0;
    req(1'b0, 64'd0, 1'b0);
    we_i = 1'b0; waddr_i = '0; wdata_i = '0;

    // Reset state
    sample();
    chk("rst_valid", 64'(valid_rsp_o), 64'd0);
    chk("rst_ready", 64'(ready_req_o), 64'd0);
    chk("rst_data",  data_rsp_o,       64'd0);
    chk("rst_err",   64'(err_rsp_o),   64'd0);
    tick();
    rst_n = 1'b1;
    sample();
    chk("post_rst_ready", 64'(ready_req_o), 64'd1);
    tick();

    // Program load
    for (int i = 0; i < 12; i++) begin
      we_i = 1'b1; waddr_i = 64'(i * 4); wdata_i = words[i];
      tick();
    end
    we_i = 1'b0;

    // Back-to-back fetch with ready_rsp high
    req(1'b1, 64'h0, 1'b1);
    sample();
    chk("bb_ready0", 64'(ready_req_o), 64'd1);
    chk("bb_novalid", 64'(valid_rsp_o), 64'd0);
    tick();
    req(1'b1, 64'h4, 1'b1); sample(); chk_rsp("bb0", words[0]); tick();
    req(1'b1, 64'h8, 1'b1); sample(); chk_rsp("bb1", words[1]); tick();
    req(1'b1, 64'hC, 1'b1); sample(); chk_rsp("bb2", words[2]); tick();
    req(1'b0, 64'h0, 1'b1); sample(); chk_rsp("bb3", words[3]); tick();
    sample(); chk("bb_empty", 64'(valid_rsp_o), 64'd0);
    tick();

    // Backpressure: buffer fills after two accepts
    req(1'b1, 64'h0, 1'b0); sample();
    chk("bp_ready0", 64'(ready_req_o), 64'd1); tick();
    req(1'b1, 64'h4, 1'b0); sample();
    chk("bp_ready1", 64'(ready_req_o), 64'd1);
    chk_rsp("bp_head0", words[0]); tick();
    req(1'b1, 64'h8, 1'b0); sample();
    chk("bp_full", 64'(ready_req_o), 64'd0);
    chk_rsp("bp_hold0", words[0]); tick();
    sample();
    chk("bp_full2", 64'(ready_req_o), 64'd0);
    chk_rsp("bp_hold1", words[0]); tick();
    req(1'b1, 64'h8, 1'b1); sample();
    chk("bp_pop_accept", 64'(ready_req_o), 64'd1);
    chk_rsp("bp_r0", words[0]); tick();
    req(1'b0, 64'h0, 1'b1); sample(); chk_rsp("bp_r1", words[1]); tick();
    sample(); chk_rsp("bp_r2", words[2]); tick();
    sample(); chk("bp_empty", 64'(valid_rsp_o), 64'd0);

    // Error responses
    req(1'b1, 64'h2, 1'b1); tick();
    req(1'b1, 64'(4 * MEM_WORDS), 1'b1); sample();
    chk("err_mis_valid", 64'(valid_rsp_o), 64'd1);
    chk("err_mis_err",   64'(err_rsp_o),   64'd1);
    chk("err_mis_data",  data_rsp_o,       64'd0);
    tick();
    req(1'b1, 64'h4, 1'b1); sample();
    chk("err_oor_err",  64'(err_rsp_o), 64'd1);
    chk("err_oor_data", data_rsp_o,     64'd0);
    tick();
    req(1'b0, 64'h0, 1'b1); sample(); chk_rsp("err_ok", words[1]); tick();

    // Same-cycle read and write to one word
    req(1'b1, 64'h8, 1'b1);
    we_i = 1'b1; waddr_i = 64'h8; wdata_i = 32'hDEAD_BEEF;
    tick();
    we_i = 1'b0;
    req(1'b1, 64'h8, 1'b1); sample(); chk_rsp("rw_old", words[2]); tick();
    req(1'b0, 64'h0, 1'b1); sample(); chk_rsp("rw_new", 32'hDEAD_BEEF); tick();

    // Full buffer, then sustained pop+accept for six cycles
    req(1'b1, 64'h10, 1'b0); tick();
    req(1'b1, 64'h14, 1'b0); tick();
    req(1'b0, 64'h0, 1'b0); sample();
    chk("fl_full", 64'(ready_req_o), 64'd0);
    tick();
    for (int k = 0; k < 6; k++) begin
      req(1'b1, 64'(4 * (6 + k)), 1'b1);
      sample();
      chk($sformatf("fl_ready%0d", k), 64'(ready_req_o), 64'd1);
      chk_rsp($sformatf("fl_r%0d", k), words[4 + k]);
      tick();
    end
    req(1'b0, 64'h0, 1'b1);
    sample(); chk_rsp("fl_r6", words[10]); tick();
    sample(); chk_rsp("fl_r7", words[11]); tick();
    sample(); chk("fl_empty", 64'(valid_rsp_o), 64'd0);

    // Reset with responses buffered
    req(1'b1, 64'h0, 1'b0); tick();
    req(1'b1, 64'h4, 1'b0); tick();
    req(1'b0, 64'h0, 1'b0); sample();
    chk("mr_pre_valid", 64'(valid_rsp_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 64'(valid_rsp_o), 64'd0);
    chk("mr_ready", 64'(ready_req_o), 64'd0);
    chk("mr_data",  data_rsp_o,       64'd0);
    tick();
    rst_n = 1'b1;
    sample();
    chk("mr_post_ready", 64'(ready_req_o), 64'd1);
    chk("mr_post_valid", 64'(valid_rsp_o), 64'd0);
    req(1'b1, 64'h0, 1'b1); tick();
    req(1'b0, 64'h0, 1'b1); sample(); chk_rsp("mr_mem", words[0]); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cprv_imem_responder.md
CPRV_IMEM_RESPONDER -- requirements
Module: cprv_imem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, the width of request address and response data.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32, the instruction word width.
REQ-003 SHALL have parameter MEM_WORDS, default 1024, the number of INSTR_WIDTH words stored (power of two).
REQ-004 SHALL have parameter RSP_DEPTH, default 2, the response buffer depth (power of two, >=2).
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port valid_req_i  input  1  fetch request valid.
REQ-008 SHALL have port ready_req_o  output  1  request can be accepted this cycle.
REQ-009 SHALL have port addr_req_i  input  DATA_WIDTH  byte address of the requested instruction.
REQ-010 SHALL have port valid_rsp_o  output  1  response valid.
REQ-011 SHALL have port ready_rsp_i  input  1  fetch side accepts the response.
REQ-012 SHALL have port data_rsp_o  output  DATA_WIDTH  instruction zero-extended to DATA_WIDTH.
REQ-013 SHALL have port err_rsp_o  output  1  response error flag, qualified by valid_rsp_o.
REQ-014 SHALL have port we_i  input  1  backdoor write enable for program loading.
REQ-015 SHALL have port waddr_i  input  DATA_WIDTH  backdoor byte address.
REQ-016 SHALL have port wdata_i  input  INSTR_WIDTH  backdoor write data.

Function
REQ-017 SHALL accept a request on a cycle where valid_req_i and ready_req_o are both 1; no other cycle accepts.
REQ-018 SHALL assert ready_req_o combinationally only when outstanding count (in-flight read + buffered responses) < RSP_DEPTH, or == RSP_DEPTH with a response popping this cycle.
REQ-019 SHALL read the word at index addr_req_i[log2(MEM_WORDS)+1:2] at acceptance, with the result entering the response buffer at the next rising edge (one-cycle read latency).
REQ-020 SHALL present a response with valid_rsp_o=1 at the earliest in the cycle after acceptance; with an empty buffer and ready_rsp_i=1, sustain one request accepted and one response popped per cycle.
REQ-021 SHALL return responses in exactly request order.
REQ-022 SHALL pop a response on valid_rsp_o and ready_rsp_i both 1; hold data_rsp_o, err_rsp_o and valid_rsp_o stable while valid_rsp_o=1 and ready_rsp_i=0.
REQ-023 SHALL set err_rsp_o=1 and data_rsp_o=0 when addr_req_i[1:0] != 0 or addr_req_i >= 4*MEM_WORDS; otherwise err_rsp_o=0 with the stored word in bits INSTR_WIDTH-1:0, upper bits 0.
REQ-024 SHALL write wdata_i to word waddr_i[log2(MEM_WORDS)+1:2] at the rising edge when we_i=1, ignoring out-of-range or misaligned waddr_i silently.
REQ-025 SHALL return the old word for a read and write to the same word in the same cycle; the new word is visible to requests accepted later.
REQ-026 SHALL handle buffer full with simultaneous pop and accept without loss, duplication or stall, and buffer pointers SHALL wrap modulo RSP_DEPTH.
REQ-027 SHALL keep the outstanding count within 0..RSP_DEPTH at all times.

Reset
REQ-028 SHALL, while rst_n=0, drive valid_rsp_o=0, err_rsp_o=0, data_rsp_o=0 and clear buffer pointers, outstanding count and in-flight flag.
REQ-029 SHALL drive ready_req_o=0 while rst_n=0 and 1 from the first cycle after release.
REQ-030 SHALL discard all in-flight and buffered responses on reset mid-operation; memory contents SHALL NOT be reset.

Verification
REQ-031 Load words 0..3 = 0x00000013,0x00100093,0x00200113,0x00300193 via we_i; requests 0x0,0x4,0x8,0xC back-to-back, ready_rsp_i=1 -> four responses in order, one per cycle starting one cycle after first acceptance, err_rsp_o=0.
REQ-032 ready_rsp_i=0, requests 0x0,0x4,0x8 -> first two accepted, ready_req_o=0 on third; raise ready_rsp_i -> 0x00000013 then 0x00100093, then third accepted and returned.
REQ-033 Request 0x2, then 4*MEM_WORDS -> both responses err_rsp_o=1, data_rsp_o=0; next request 0x4 -> err_rsp_o=0, data 0x00100093.
REQ-034 Same cycle: we_i=1 waddr 0x8 wdata 0xDEADBEEF and request 0x8 -> response 0x00200113; next request 0x8 -> 0xDEADBEEF.
REQ-035 Buffer full (ready_rsp_i=0, two responses held), assert ready_rsp_i with valid_req_i=1 every cycle for 6 cycles -> 6 accepts, no stall, responses in address order.
REQ-036 Pull rst_n low with two responses buffered -> valid_rsp_o=0 immediately; after release, ready_req_o=1 and memory still returns 0x00000013 at 0x0.
